mpy_4bit: RTL and testbench
===========================

MPY_4BIT -- requirements
Module: mpy_4bit

Interface
REQ-001 The block SHALL have one parameter: N, default 4, operand width in bits; this release is verified only at N=4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port a, input, N bits: unsigned multiplicand.
REQ-005 The block SHALL have port b, input, N bits: unsigned multiplier.
REQ-006 The block SHALL have port product, output, 2N bits: registered unsigned product a*b.

Function
REQ-007 The block SHALL compute the full-width unsigned product with no truncation, overflow or sign handling (max 15*15=225).
REQ-008 The block SHALL use an iterative shift-add datapath (one partial-product bit per cycle), not a combinational array multiplier.
REQ-009 The block SHALL have no start or valid handshake; a change of a or b SHALL start a new computation.
REQ-010 The block SHALL hold internal registers a_q (N bits), b_q (N bits), acc (2N bits), cnt (log2(N)+1 bits) and state.
REQ-011 State IDLE: if {a,b} differs from {a_q,b_q} at a rising edge, the block SHALL latch a_q<=a, b_q<=b, clear acc and cnt, and go to CALC; otherwise it stays in IDLE.
REQ-012 State CALC: each cycle the block SHALL add the shifted a_q into acc if the current b_q bit is 1, shift, and increment cnt; after N iterations it SHALL go to DONE.
REQ-013 CALC mid-operation change: if {a,b} differs from {a_q,b_q} at a rising edge in CALC, the block SHALL abort, relatch the operands, clear acc and cnt, and restart CALC.
REQ-014 State DONE: the block SHALL write product<=acc and return to IDLE.
REQ-015 The product register SHALL change only in DONE or on reset, and SHALL hold the last completed result at all other times.
REQ-016 Latency: if operands change at edge E0, the first detection is at E1 and product SHALL be valid after edge E1+N+1 (E6 for N=4), then stable while the inputs are stable.
REQ-017 Operands equal to the previous ones SHALL NOT start a computation, and product SHALL stay unchanged.
REQ-018 Back-to-back operand changes spaced at least N+2 cycles apart SHALL each produce their own correct product.

Reset
REQ-019 While rst=1 (asynchronous, no clock needed), the block SHALL force product=0, a_q=0, b_q=0, acc=0, cnt=0 and state=IDLE.
REQ-020 After reset with a=b=0, product SHALL already be correct (0) and no computation SHALL start.
REQ-021 Reset asserted during CALC SHALL discard the computation; after release, the current inputs SHALL be recomputed per REQ-011 if non-zero.

Structure
REQ-022 A shared package SHALL hold the parameter default N=4 and the state encoding IDLE/CALC/DONE (2-bit).
REQ-023 The design SHALL be a single module with one sequential FSM/datapath process and combinational next-state logic; no sub-module is required.

Verification
REQ-024 Reset, then a=0, b=0 -> product=0 at every edge with no cycle mismatched.
REQ-025 a=9, b=6 applied at E0 -> product=54 by E6 and held through E11.
REQ-026 a=15, b=15 -> product=225 (full 8-bit range); then a=0, b=7 -> product=0.
REQ-027 a=5, b=3 at E0, changed to a=12, b=11 at E3 (mid-CALC) -> 15 never appears; product=132 by E9.
REQ-028 rst pulsed during CALC of a=7, b=7 -> product=0 immediately; after release with inputs held -> product=49 within N+2 cycles.
REQ-029 Ten random operand pairs, each held 11 cycles -> product equals a*b at the end of each window; 10/10 correct.

Source files
------------

// File: rtl/mpy_4bit_pkg.sv
// Shared definitions for the iterative 4-bit shift-add multiplier.
package mpy_4bit_pkg;

  // Default operand width in bits.
  localparam int unsigned N_DEFAULT = 4;

  // Controller state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mpy_4bit.sv
// Iterative unsigned shift-add multiplier.
// Any change of the operands starts a new computation. One partial-product
// bit is accumulated per cycle. The product register only updates once a
// computation has completed, so it holds the last finished result.
module mpy_4bit
  import mpy_4bit_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product
);

  localparam int unsigned CW = $clog2(N) + 1;

  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  cnt;
  state_t         state;

  logic           changed;
  logic [N-1:0]   b_shifted;
  logic [2*N-1:0] addend;
  logic           last_iter;

  // Operand-change detection and the partial product for the current bit.
  always_comb begin
    changed   = ({a, b} != {a_q, b_q});
    b_shifted = b_q >> cnt;
    addend    = '0;
    if (b_shifted[0]) begin
      addend = (2*N)'(a_q) << cnt;
    end
    last_iter = (cnt == CW'(N - 1));
  end

  // Controller and datapath: latch operands, accumulate, publish result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (changed) begin
            a_q   <= a;
            b_q   <= b;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          if (changed) begin
            // Operands moved mid-computation: discard progress and restart.
            a_q   <= a;
            b_q   <= b;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end else begin
            acc <= acc + addend;
            cnt <= cnt + CW'(1);
            if (last_iter) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          product <= acc;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpy_4bit.sv
// Scoreboard bench for mpy_4bit: stimulus pushes the expected product for
// every cycle of each operand window; a negedge monitor pops and compares.
module tb_mpy_4bit;

  localparam int unsigned N   = 4;
  localparam int unsigned LAT = N + 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   a   = '0;
  logic [N-1:0]   b   = '0;
  logic [2*N-1:0] product;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [2*N-1:0] last = '0;

  typedef struct {
    int unsigned    cyc;
    logic [2*N-1:0] exp;
    string          tag;
  } exp_t;

  exp_t sb[$];

  mpy_4bit #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .product (product)
  );

  always #5 clk = ~clk;

  // Count rising edges so windows can be addressed by edge number.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: product=%0d expected=%0d at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  // Monitor: compare every due scoreboard entry on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check(e.tag, product, e.exp);
    end
  end

  // Expected product for each of the next 'hold' edges after edge 'base':
  // the previous result until the new one is published LAT edges later.
  task automatic push_window(input logic [N-1:0] x, input logic [N-1:0] y,
                             input int unsigned hold, input string tag,
                             input int unsigned base);
    exp_t e;
    int   p;
    p = int'(x) * int'(y);
    for (int unsigned k = 1; k <= hold; k++) begin
      e.cyc = base + k;
      e.exp = (k >= LAT) ? (2*N)'(p) : last;
      e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic window(input logic [N-1:0] x, input logic [N-1:0] y,
                        input int unsigned hold, input string tag);
    int unsigned base;
    int          p;
    @(negedge clk);
    a    = x;
    b    = y;
    base = cyc;
    push_window(x, y, hold, tag, base);
    repeat (hold - 1) @(negedge clk);
    if (hold >= LAT) begin
      p    = int'(x) * int'(y);
      last = (2*N)'(p);
    end
  endtask

  initial begin : stimulus
    logic [N-1:0] rx, ry;

    #1;
    check("reset_state", product, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    window(4'd0,  4'd0,  8,  "zero_after_reset");
    window(4'd9,  4'd6,  12, "mul_9x6");
    window(4'd9,  4'd6,  8,  "same_operands");
    window(4'd15, 4'd15, 8,  "mul_15x15");
    window(4'd0,  4'd7,  8,  "mul_0x7");

    // Change operands after three edges, while the first product is in flight.
    window(4'd5,  4'd3,  3,  "abort_5x3");
    window(4'd12, 4'd11, 10, "mul_12x11");

    // Asynchronous reset in the middle of a computation.
    window(4'd7, 4'd7, 2, "rst_pre_7x7");
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async_clear", product, '0);
    last = '0;
    @(negedge clk);
    rst = 1'b0;
    push_window(4'd7, 4'd7, 8, "rst_recalc_7x7", cyc);
    repeat (7) @(negedge clk);
    last = 8'd49;

    for (int i = 0; i < 10; i++) begin
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 15));
      window(rx, ry, 11, "random_pair");
    end

    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #50000;
    $display("FAIL timeout: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
